// File: rtl/pulse_seq_ctrl_if.sv
// pulse_seq_ctrl_if: 8-bit Avalon-MM register port of the pulse sequencer
interface pulse_seq_ctrl_if;
   logic [3:0] avs_s0_address;
   logic [7:0] avs_s0_writedata;
   logic       avs_s0_write;
   logic       avs_s0_read;
   logic [7:0] avs_s0_readdata;
   modport master (output avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read, input avs_s0_readdata);
   modport slave (input avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read, output avs_s0_readdata);
endinterface

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: Avalon-programmed pulse-train sequencer with continuous and counted modes
module pulse_seq_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   pulse_seq_ctrl_if.slave  avs_s0,
   input  logic             start,
   input  logic             stop,
   input  logic             start_N,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt
);
   localparam logic [1:0] S_IDLE = 2'd0, S_ON = 2'd1, S_OFF = 2'd2, S_FIN = 2'd3;
   localparam int HI_W = CNT_W - 8;
   localparam logic [CNT_W-1:0] C1 = 1, C2 = 2;
   logic [1:0]       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_period, r_width, r_count;
   logic [CNT_W-1:0] r_per, r_wid, r_cnt, r_tmr, r_pulse_cnt;
   logic [CNT_W-1:0] w_per_s, w_wid_z, w_wid_s, w_tmr_nxt;
   logic             r_invert, r_mode_n, r_sticky, r_pulse;
   logic [7:0]       r_rdata, w_rd;
   logic             w_idle, w_go, w_go_n, w_inv_nxt, w_wr, w_rd_stat;
   logic [3:0]       w_addr;
   logic [7:0]       w_wd;
   assign w_addr    = avs_s0.avs_s0_address;
   assign w_wd      = avs_s0.avs_s0_writedata;
   assign w_wr      = avs_s0.avs_s0_write;
   assign w_rd_stat = avs_s0.avs_s0_read && w_addr == 4'd7;
   assign w_idle    = r_state == S_IDLE;
   assign w_go_n    = w_idle && start_N && !stop;
   assign w_go      = w_idle && start && !start_N && !stop;
   assign w_per_s   = r_period < C2 ? C2 : r_period;
   assign w_wid_z   = r_width == '0 ? C1 : r_width;
   assign w_wid_s   = w_wid_z >= w_per_s ? w_per_s - C1 : w_wid_z;
   assign w_inv_nxt = w_wr && w_addr == 4'd6 ? w_wd[0] : r_invert;
   assign busy      = !w_idle;
   assign done      = r_state == S_FIN;
   assign pulse_out = r_pulse;
   assign pulse_cnt = r_pulse_cnt;
   assign avs_s0.avs_s0_readdata = r_rdata;
   // next state and down-counting phase timer; entry from IDLE uses freshly sanitised values
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr - C1;
      if (w_idle) begin
         w_state_nxt = (w_go_n && r_count == '0) ? S_FIN : (w_go || w_go_n) ? S_ON : S_IDLE;
         w_tmr_nxt   = w_wid_s - C1;
      end else if (r_state == S_FIN || stop) begin
         w_state_nxt = S_IDLE;
      end else if (r_tmr == '0) begin
         w_state_nxt = r_state == S_ON ? S_OFF : (r_mode_n && r_pulse_cnt == r_cnt) ? S_FIN : S_ON;
         w_tmr_nxt   = r_state == S_ON ? r_per - r_wid - C1 : r_wid - C1;
      end
   end
   // register read mux; HI registers return only the implemented counter bits
   always_comb begin
      w_rd = 8'd0;
      case (w_addr)
         4'd0:    w_rd = r_period[7:0];
         4'd1:    w_rd = 8'(r_period[CNT_W-1:8]);
         4'd2:    w_rd = r_width[7:0];
         4'd3:    w_rd = 8'(r_width[CNT_W-1:8]);
         4'd4:    w_rd = r_count[7:0];
         4'd5:    w_rd = 8'(r_count[CNT_W-1:8]);
         4'd6:    w_rd = {7'd0, r_invert};
         4'd7:    w_rd = {5'd0, r_sticky, r_mode_n, busy};
         default: w_rd = 8'd0;
      endcase
   end
   // FSM state, timer and the registered output pin (raw pulse of the coming cycle XOR invert)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
         r_pulse <= (w_state_nxt == S_ON) ^ w_inv_nxt;
      end
   end
   // working copies captured on an accepted start so register writes only affect the next run
   always_ff @(posedge clk) begin
      if (rst) begin
         r_per       <= '0;
         r_wid       <= '0;
         r_cnt       <= '0;
         r_mode_n    <= 1'b0;
         r_pulse_cnt <= '0;
      end else if (w_go || w_go_n) begin
         r_per       <= w_per_s;
         r_wid       <= w_wid_s;
         r_cnt       <= r_count;
         r_mode_n    <= w_go_n;
         r_pulse_cnt <= '0;
      end else if (r_state == S_ON && r_tmr == r_wid - C1 && r_pulse_cnt != '1) begin
         r_pulse_cnt <= r_pulse_cnt + C1;
      end
   end
   // programmable registers, sticky done flag and registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_period <= '0;
         r_width  <= '0;
         r_count  <= '0;
         r_invert <= 1'b0;
         r_sticky <= 1'b0;
         r_rdata  <= 8'd0;
      end else begin
         r_invert <= w_inv_nxt;
         r_sticky <= done || (r_sticky && !w_rd_stat);
         if (avs_s0.avs_s0_read) r_rdata <= w_rd;
         if (w_wr) begin
            case (w_addr)
               4'd0:    r_period[7:0]       <= w_wd;
               4'd1:    r_period[CNT_W-1:8] <= w_wd[HI_W-1:0];
               4'd2:    r_width[7:0]        <= w_wd;
               4'd3:    r_width[CNT_W-1:8]  <= w_wd[HI_W-1:0];
               4'd4:    r_count[7:0]        <= w_wd;
               4'd5:    r_count[CNT_W-1:8]  <= w_wd[HI_W-1:0];
               default: ;
            endcase
         end
      end
   end
endmodule
